fetch_unit: RTL and testbench

Instruction fetch stage between the 128-word program RAM (`ram_rw_16x128`, registered read, one-cycle latency) and the decode/execute logic of `proc`. It generates `pc` and `ram_read_en`, captures returned words into a small prefetch FIFO, and presents them to decode with a valid/ready handshake. It also supports control-flow redirects and stops fetching on the halt word `16'h3c00`.

---
 rtl/proc_pkg.sv | 13 +
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_fifo.sv | 44 ++++
 rtl/fetch_unit.sv | 94 +++++++++
 tb/tb_fetch_unit.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/proc_pkg.sv
// Shared fetch-stage definitions: default widths, halt word and fetch FSM encodings.
package proc_pkg;

    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 16;

    localparam logic [15:0] HALT_INSTR = 16'h3c00;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch bus: program RAM read port on one side, decode handshake and redirect on the other.
interface fetch_unit_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] pc;
    logic              ram_read_en;
    logic [DATA_W-1:0] ram_dout;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halted;

    modport master (
        output pc, ram_read_en, instr, instr_pc, instr_valid, halted,
        input  ram_dout, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  pc, ram_read_en, instr, instr_pc, instr_valid, halted,
        output ram_dout, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO; pointers carry an extra wrap bit so full and empty are distinguishable.
module fetch_fifo #(
    parameter int WIDTH = 23,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues program RAM reads, queues returned words, handles redirects.
// Define FETCH_HALT_DETECT_EN to stop fetching once the halt word is returned.
module fetch_unit
    import proc_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    fetch_unit_if.master  bus
);
    // state     | meaning
    // ST_IDLE   | after reset, waiting for start
    // ST_FETCH  | issuing reads while the FIFO has room
    // ST_HALTED | halt word seen, no reads until redirect
    localparam int CW = $clog2(DEPTH) + 1;

    logic [1:0]               state_q, state_d;
    logic [ADDR_W-1:0]        pc_q, tag_q;
    logic                     inflight_q, squash_q;
    logic [CW-1:0]            count;
    logic [CW:0]              occ;
    logic                     full, empty;
    logic                     push, pop, issue, halt_hit;
    logic [DATA_W+ADDR_W-1:0] head;

    // A response is dropped if a redirect happened when it was issued or arrives with one.
    assign push = inflight_q && !squash_q && !bus.redirect;

`ifdef FETCH_HALT_DETECT_EN
    assign halt_hit    = push && (bus.ram_dout == DATA_W'(HALT_INSTR));
    assign bus.halted  = (state_q == ST_HALTED);
`else
    assign halt_hit    = 1'b0;
    assign bus.halted  = 1'b0;
`endif

    assign occ   = {1'b0, count} + (CW+1)'(inflight_q);
    assign issue = (state_q == ST_FETCH) && (occ < (CW+1)'(DEPTH)) && !full && !halt_hit;
    assign pop   = !empty && bus.instr_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_FETCH;
            ST_FETCH:  if (halt_hit) state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
        if (bus.redirect) state_d = ST_FETCH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            tag_q      <= '0;
            inflight_q <= 1'b0;
            squash_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= issue;
            squash_q   <= bus.redirect;
            if (issue) tag_q <= pc_q;
            if (bus.redirect) pc_q <= bus.redirect_pc;
            else if (issue)   pc_q <= pc_q + ADDR_W'(1);
        end
    end

    fetch_fifo #(
        .WIDTH (DATA_W + ADDR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect),
        .wdata ({bus.ram_dout, tag_q}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign bus.pc          = pc_q;
    assign bus.ram_read_en = issue;
    assign bus.instr       = head[DATA_W+ADDR_W-1:ADDR_W];
    assign bus.instr_pc    = head[ADDR_W-1:0];
    assign bus.instr_valid = !empty;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural one-cycle-latency program RAM.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    logic [15:0] ram [128];

    fetch_unit_if #(.ADDR_W(7), .DATA_W(16)) bus ();

    fetch_unit #(.ADDR_W(7), .DATA_W(16), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.ram_read_en) bus.ram_dout <= ram[bus.pc];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 0 with start high.
    task automatic reset_and_start();
        start = 1'b0;
        bus.redirect = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        start = 1'b1;
    endtask

    task automatic test_reset();
        tick();
        n_cmp++; if (bus.pc !== 7'h00) begin n_fail++; $display("FAIL rst_pc got=%h exp=00", bus.pc); end
        n_cmp++; if (bus.ram_read_en !== 1'b0) begin n_fail++; $display("FAIL rst_read_en got=%b exp=0", bus.ram_read_en); end
        n_cmp++; if (bus.instr !== 16'h0000) begin n_fail++; $display("FAIL rst_instr got=%h exp=0000", bus.instr); end
        n_cmp++; if (bus.instr_pc !== 7'h00) begin n_fail++; $display("FAIL rst_instr_pc got=%h exp=00", bus.instr_pc); end
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", bus.instr_valid); end
        n_cmp++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted got=%b exp=0", bus.halted); end
        rst_n = 1'b1;
        tick();
        tick();
        n_cmp++; if (bus.ram_read_en !== 1'b0) begin n_fail++; $display("FAIL idle_no_issue got=%b exp=0", bus.ram_read_en); end
    endtask

    task automatic test_stream();
        bus.instr_ready = 1'b1;
        reset_and_start();
        tick();
        start = 1'b0;
        n_cmp++; if (bus.ram_read_en !== 1'b1) begin n_fail++; $display("FAIL first_read_en got=%b exp=1", bus.ram_read_en); end
        n_cmp++; if (bus.pc !== 7'h00) begin n_fail++; $display("FAIL first_pc got=%h exp=00", bus.pc); end
        tick();
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL cycle2_valid got=%b exp=0", bus.instr_valid); end
        tick();
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, bus.instr_valid); end
            n_cmp++; if (bus.instr !== 16'(i)) begin n_fail++; $display("FAIL stream_instr[%0d] got=%h exp=%h", i, bus.instr, 16'(i)); end
            n_cmp++; if (bus.instr_pc !== 7'(i)) begin n_fail++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, bus.instr_pc, 7'(i)); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        bus.instr_ready = 1'b0;
        n_cmp++; if (bus.instr_pc !== 7'h06) begin n_fail++; $display("FAIL bp_head got=%h exp=06", bus.instr_pc); end
        repeat (10) tick();
        n_cmp++; if (bus.ram_read_en !== 1'b0) begin n_fail++; $display("FAIL bp_read_en got=%b exp=0", bus.ram_read_en); end
        n_cmp++; if (dut.u_fifo.count !== 3'd4) begin n_fail++; $display("FAIL bp_occupancy got=%0d exp=4", dut.u_fifo.count); end
        n_cmp++; if (bus.instr_pc !== 7'h06) begin n_fail++; $display("FAIL bp_head_held got=%h exp=06", bus.instr_pc); end
        bus.instr_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 7'(6 + j) || bus.instr !== 16'(6 + j))
                begin n_fail++; $display("FAIL bp_drain[%0d] got=%b/%h/%h exp=1/%h/%h", j, bus.instr_valid, bus.instr_pc, bus.instr, 7'(6 + j), 16'(6 + j)); end
            tick();
        end
    endtask

    task automatic test_redirect();
        bus.instr_ready = 1'b1;
        reset_and_start();
        repeat (7) tick();
        start = 1'b0;
        bus.redirect = 1'b1;
        bus.redirect_pc = 7'h40;
        tick();
        bus.redirect = 1'b0;
        n_cmp++; if (bus.ram_read_en !== 1'b1 || bus.pc !== 7'h40) begin n_fail++; $display("FAIL redir_issue got=%b/%h exp=1/40", bus.ram_read_en, bus.pc); end
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush got=%b exp=0", bus.instr_valid); end
        tick();
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_squash got=%b/%h exp=0", bus.instr_valid, bus.instr_pc); end
        tick();
        n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 7'h40 || bus.instr !== 16'h0040)
            begin n_fail++; $display("FAIL redir_target got=%b/%h/%h exp=1/40/0040", bus.instr_valid, bus.instr_pc, bus.instr); end
        tick();
        n_cmp++; if (bus.instr_pc !== 7'h41) begin n_fail++; $display("FAIL redir_next got=%h exp=41", bus.instr_pc); end
    endtask

    task automatic test_wrap();
        logic [6:0] exp_pc [5];
        exp_pc = '{7'h7d, 7'h7e, 7'h7f, 7'h00, 7'h01};
        bus.instr_ready = 1'b1;
        bus.redirect = 1'b1;
        bus.redirect_pc = 7'h7d;
        tick();
        bus.redirect = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== exp_pc[k] || bus.instr !== {9'h0, exp_pc[k]})
                begin n_fail++; $display("FAIL wrap[%0d] got=%b/%h/%h exp=1/%h", k, bus.instr_valid, bus.instr_pc, bus.instr, exp_pc[k]); end
            tick();
        end
    endtask

    task automatic test_halt();
        ram[16] = 16'h3c00;
        bus.instr_ready = 1'b1;
        reset_and_start();
        repeat (18) tick();
        start = 1'b0;
`ifdef FETCH_HALT_DETECT_EN
        n_cmp++; if (bus.ram_read_en !== 1'b0) begin n_fail++; $display("FAIL halt_no_issue got=%b exp=0", bus.ram_read_en); end
`else
        n_cmp++; if (bus.ram_read_en !== 1'b1 || bus.pc !== 7'h11) begin n_fail++; $display("FAIL nohalt_issue got=%b/%h exp=1/11", bus.ram_read_en, bus.pc); end
`endif
        tick();
        n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr !== 16'h3c00 || bus.instr_pc !== 7'h10)
            begin n_fail++; $display("FAIL halt_word got=%b/%h/%h exp=1/3c00/10", bus.instr_valid, bus.instr, bus.instr_pc); end
`ifdef FETCH_HALT_DETECT_EN
        n_cmp++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL halted_set got=%b exp=1", bus.halted); end
        tick();
        n_cmp++; if (bus.instr_valid !== 1'b0 || bus.ram_read_en !== 1'b0 || bus.halted !== 1'b1)
            begin n_fail++; $display("FAIL halt_drained got=%b/%b/%b exp=0/0/1", bus.instr_valid, bus.ram_read_en, bus.halted); end
`else
        n_cmp++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL halted_tied got=%b exp=0", bus.halted); end
        tick();
        n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 7'h11)
            begin n_fail++; $display("FAIL nohalt_next got=%b/%h exp=1/11", bus.instr_valid, bus.instr_pc); end
`endif
        bus.redirect = 1'b1;
        bus.redirect_pc = 7'h20;
        tick();
        bus.redirect = 1'b0;
        n_cmp++; if (bus.ram_read_en !== 1'b1 || bus.pc !== 7'h20 || bus.halted !== 1'b0)
            begin n_fail++; $display("FAIL halt_redirect got=%b/%h/%b exp=1/20/0", bus.ram_read_en, bus.pc, bus.halted); end
        ram[16] = 16'h0010;
    endtask

    task automatic test_reset_mid();
        bus.instr_ready = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #2;
        n_cmp++; if (bus.pc !== 7'h00 || bus.ram_read_en !== 1'b0) begin n_fail++; $display("FAIL mid_rst_pc got=%h/%b exp=00/0", bus.pc, bus.ram_read_en); end
        n_cmp++; if (bus.instr_valid !== 1'b0 || bus.instr !== 16'h0 || bus.instr_pc !== 7'h0)
            begin n_fail++; $display("FAIL mid_rst_head got=%b/%h/%h exp=0/0000/00", bus.instr_valid, bus.instr, bus.instr_pc); end
        bus.instr_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        start = 1'b1;
        tick();
        n_cmp++; if (bus.ram_read_en !== 1'b1 || bus.pc !== 7'h00) begin n_fail++; $display("FAIL restart_issue got=%b/%h exp=1/00", bus.ram_read_en, bus.pc); end
        tick();
        tick();
        n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 7'h00) begin n_fail++; $display("FAIL restart_head got=%b/%h exp=1/00", bus.instr_valid, bus.instr_pc); end
    endtask

    initial begin
        for (int a = 0; a < 128; a++) ram[a] = 16'(a);
        bus.instr_ready = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 7'h00;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_halt();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
